// File: rtl/kogge_stone.sv
// rtl/kogge_stone.sv - registered Kogge-Stone parallel-prefix adder
//
// Computes {Cout, S} = A + B + Cin through an explicit log2(WIDTH)-level
// prefix network, with the result registered (one pipeline stage).
// Optional macro KS_IN_REG_EN adds input registers in front of the adder,
// raising latency from 1 to 2 cycles without changing the function.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears all registers)
//   A, B   - unsigned operands, WIDTH bits
//   Cin    - carry-in
//   S      - registered sum, (A + B + Cin) mod 2^WIDTH
//   Cout   - registered carry-out, bit WIDTH of A + B + Cin
module kogge_stone #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int LVLS = $clog2(WIDTH);

    // Operands actually fed to the prefix network
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic             cin_op;

`ifdef KS_IN_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= A;
            b_q   <= B;
            cin_q <= Cin;
        end
    end

    assign a_op   = a_q;
    assign b_op   = b_q;
    assign cin_op = cin_q;
`else
    assign a_op   = A;
    assign b_op   = B;
    assign cin_op = Cin;
`endif

    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] g_bit;

    assign p_bit = a_op ^ b_op;
    assign g_bit = a_op & b_op;

    // g_lvl[k]/p_lvl[k] hold group generate/propagate entering level k.
    // The final level's propagate is never consumed, so p_lvl stops one short.
    wire [WIDTH-1:0] g_lvl [0:LVLS];
    wire [WIDTH-1:0] p_lvl [0:LVLS-1];

    // Carry-in folded into bit 0 so the network never has to treat it specially
    assign g_lvl[0] = {g_bit[WIDTH-1:1], g_bit[0] | (p_bit[0] & cin_op)};
    assign p_lvl[0] = p_bit;

    generate
        for (genvar k = 0; k < LVLS; k++) begin : g_level
            localparam int D = 1 << k;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bitpos
                if (i >= D) begin : g_merge
                    assign g_lvl[k+1][i] = g_lvl[k][i] | (p_lvl[k][i] & g_lvl[k][i-D]);
                    if (k < LVLS - 1) begin : g_pmerge
                        assign p_lvl[k+1][i] = p_lvl[k][i] & p_lvl[k][i-D];
                    end
                end else begin : g_pass
                    assign g_lvl[k+1][i] = g_lvl[k][i];
                    if (k < LVLS - 1) begin : g_ppass
                        assign p_lvl[k+1][i] = p_lvl[k][i];
                    end
                end
            end
        end
    endgenerate

    // c_0 = Cin, c_i = final group generate of bits [i-1:0]
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;

    assign carry  = {g_lvl[LVLS][WIDTH-2:0], cin_op};
    assign s_d    = p_bit ^ carry;
    assign cout_d = g_lvl[LVLS][WIDTH-1];

    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_kogge_stone.sv
// tb/tb_kogge_stone.sv - self-checking bench for kogge_stone
module tb_kogge_stone;

`ifdef KS_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [15:0] S;
    logic        Cout;

    int errors = 0;
    int checks = 0;

    kogge_stone #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .S     (S),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    // Reference: plain 17-bit arithmetic of what was presented at each edge
    int          ecount = 0;
    int          valid_cnt = 0;
    logic [16:0] h1 = '0;
    logic [16:0] h2 = '0;

    always @(posedge clk) begin
        ecount = ecount + 1;
        h2 = h1;
        h1 = {1'b0, A} + {1'b0, B} + {16'd0, Cin};
        if (!rst_n) valid_cnt = 0;
        else if (valid_cnt < LAT) valid_cnt = valid_cnt + 1;
    end

    always @(negedge rst_n) valid_cnt = 0;

    // Hand-computed expectations, each due after a specific edge
    int          lit_edge[$];
    logic [16:0] lit_val[$];
    string       lit_name[$];

    task automatic expect_lit(input string nm, input logic [16:0] v);
        // vector is on the pins now, sampled at edge ecount+1
        lit_edge.push_back(ecount + LAT);
        lit_val.push_back(v);
        lit_name.push_back(nm);
    endtask

    always @(negedge clk) begin
        logic [16:0] exp_v;
        if (!rst_n || valid_cnt < LAT) exp_v = '0;
        else exp_v = (LAT == 1) ? h1 : h2;
        checks = checks + 1;
        if ({Cout, S} !== exp_v) begin
            errors = errors + 1;
            $display("FAIL model edge=%0d got=%05h want=%05h", ecount, {Cout, S}, exp_v);
        end
        while (lit_edge.size() > 0 && lit_edge[0] <= ecount) begin
            checks = checks + 1;
            if (lit_edge[0] != ecount || {Cout, S} !== lit_val[0]) begin
                errors = errors + 1;
                $display("FAIL %s got=%05h want=%05h (due edge %0d, now %0d)",
                         lit_name[0], {Cout, S}, lit_val[0], lit_edge[0], ecount);
            end
            void'(lit_edge.pop_front());
            void'(lit_val.pop_front());
            void'(lit_name.pop_front());
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(posedge clk);
        #1;
        A   = a;
        B   = b;
        Cin = c;
    endtask

    initial begin
        rst_n = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if ({Cout, S} !== 17'h0) begin
            errors = errors + 1;
            $display("FAIL reset_state got=%05h want=00000", {Cout, S});
        end
        rst_n = 1'b1;

        drive(16'h1111, 16'hABCD, 1'b0); expect_lit("basic", 17'h0BCDE);
        drive(16'h0000, 16'h0000, 1'b0);
        drive(16'hFFFF, 16'h0001, 1'b0); expect_lit("wrap_b1", 17'h10000);
        drive(16'hFFFF, 16'h0000, 1'b1); expect_lit("wrap_cin", 17'h10000);
        drive(16'h8000, 16'h8000, 1'b1); expect_lit("msb_cin", 17'h10001);
        drive(16'hFFFF, 16'hFFFF, 1'b1); expect_lit("all_ones", 17'h1FFFF);
        drive(16'h0001, 16'h0001, 1'b0); expect_lit("b2b_0", 17'h00002);
        drive(16'h7FFF, 16'h0001, 1'b0); expect_lit("b2b_1", 17'h08000);
        drive(16'h00FF, 16'h0F01, 1'b0); expect_lit("b2b_2", 17'h01000);

        // Asynchronous reset while the output is nonzero
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (LAT) @(posedge clk);
        #2;
        checks = checks + 1;
        if ({Cout, S} !== 17'h1FFFF) begin
            errors = errors + 1;
            $display("FAIL pre_reset got=%05h want=1ffff", {Cout, S});
        end
        rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if ({Cout, S} !== 17'h0) begin
            errors = errors + 1;
            $display("FAIL async_reset got=%05h want=00000", {Cout, S});
        end
        drive(16'h1234, 16'h4321, 1'b1);
        drive(16'h1111, 16'hABCD, 1'b0);
        rst_n = 1'b1;
        expect_lit("post_reset", 17'h0BCDE);

        for (int n = 0; n < 10000; n++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom));
        end
        drive(16'hFFFF, 16'h0001, 1'b1); expect_lit("tail", 17'h10001);
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (lit_edge.size() != 0) begin
            errors = errors + 1;
            $display("FAIL pending_literals got=%0d want=0", lit_edge.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
